dsp_mac_sequencer: RTL
======================

Name: dsp_mac_sequencer

Overview:
- Controller that runs one multiply-accumulate slice (A/B/M/P/OPMODE registered configuration) as a dot-product engine.
- Accepts a job of N operand pairs over a valid/ready stream and feeds them to the slice.
- Issues per-slot OPMODE words aligned to the slice pipeline, waits for the pipeline to drain, then captures P as the result.
- Sits between the operand source (memory reader/FIFO) and a single slice instance.

Parameters:
- LEN_W, 10, width of the job length field; max N = 2^LEN_W-1.
- OP_DLY, 1, cycles between presenting operands on dsp_a/dsp_b and presenting the matching OPMODE (slice A1/B1 stage ahead of the OPMODE register).
- P_LAT, 3, cycles from operand presentation to the corresponding sum appearing on dsp_p.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  job start pulse; sampled only in IDLE.
- cfg_len  in  LEN_W  number of operand pairs N, sampled with start.
- busy  out  1  high in RUN/DRAIN/DONE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts a pair this cycle.
- in_a  in  18  operand A (unsigned).
- in_b  in  18  operand B (unsigned).
- dsp_a  out  18  to slice A.
- dsp_b  out  18  to slice B.
- dsp_opmode  out  8  to slice OPMODE.
- dsp_ce  out  1  drives all slice CE inputs.
- dsp_rst  out  1  drives all slice RST inputs.
- dsp_p  in  48  slice P output.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  48  result, held until the next result.

Behaviour:
- Reset: all outputs 0, state IDLE, slot pipeline cleared.
- Reset mid-job abandons the job; no res_valid is produced.
- dsp_rst = rst.
- dsp_ce = 1 whenever not in reset.
- States:
  - IDLE: start=1 latches cfg_len into remaining count. If N=0, go to DONE with result 0. Otherwise go to RUN.
  - RUN: in_ready=1. A transfer occurs when in_valid&in_ready. On a transfer, dsp_a/dsp_b take in_a/in_b and remaining decrements. When no transfer occurs, dsp_a/dsp_b are 0 (bubble). The transfer that brings remaining to 0 moves the FSM to DRAIN.
  - DRAIN: in_ready=0. Wait until the last slot has exited the pipeline (P_LAT cycles after its presentation), then go to DONE.
  - DONE: res_data <= dsp_p, res_valid=1 for one cycle, then IDLE. For N=0, res_data=0 and dsp_p is not sampled.
- Slot pipeline: each RUN/DRAIN cycle pushes a tag {valid, first} into a shift register of depth OP_DLY. `first` marks the first accepted pair of the job.
- Tag emerging after OP_DLY cycles selects dsp_opmode:
  - first: 8'b0000_0001 (P = 0 + M).
  - valid, not first: 8'b0000_1001 (P = P + M).
  - bubble: 8'b0000_1000 (P = P + 0).
  - idle/reset: 8'b0000_0000.
- Bits 7:4 are always 0: no pre-adder, add mode, carry-in 0.
- Arithmetic: 18x18 unsigned product, 48-bit accumulation, wrap modulo 2^48, no saturation.
- Result = sum over i of a_i*b_i mod 2^48.
- Bubbles (in_valid low in RUN) never change the result; only the cycle count grows.
- start while busy is ignored; cfg_len changes while busy have no effect.
- Back-to-back jobs: start is accepted in the cycle after DONE. The new job's first slot uses OPMODE 0000_0001, so the previous P is discarded.
- Latency, all pairs streamed back-to-back: res_valid is asserted N+P_LAT+1 cycles after the start cycle.

Optional Feature:
- Macro DSP_MAC_STALL_CNT_EN.
- Defined: adds output stall_cnt (16 bits). Cleared on rst and on accepted start; increments each RUN cycle with in_valid=0; saturates at 16'hFFFF; holds its value after DONE.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- N=4, pairs (1,2),(3,4),(5,6),(7,8) streamed without gaps -> res_data=100, res_valid exactly once, 8 cycles after start.
- N=3, pairs (2^17,2^17) x3 with in_valid low 2 cycles between pairs -> res_data=3*2^34=51539607552; stall_cnt=4 when the macro is enabled.
- N=0 start -> DONE next cycle, res_data=0, in_ready never high.
- Two back-to-back jobs: N=2 (10,10),(1,1) then N=1 (3,5) -> results 101 then 15 (no carry-over of P).
- rst asserted in RUN after 2 of 4 pairs -> outputs 0, state IDLE, no res_valid; a following N=1 (6,7) job -> 42.
- start pulsed during RUN with cfg_len=9 -> ignored; current N=2 job (4,4),(5,5) completes with 41.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer
//
// Runs one registered multiply-accumulate slice as a dot-product engine.
// A job of N operand pairs is accepted over a valid/ready stream, each pair
// is presented to the slice, and a per-slot OPMODE word is issued OP_DLY
// cycles later so it lines up with the slice's internal pipeline. Once the
// last slot has left the pipeline, P is captured as the job result.
//
// Parameters
//   LEN_W   width of the job length field (max N = 2^LEN_W-1)
//   OP_DLY  cycles between operand presentation and its OPMODE word
//   P_LAT   cycles from operand presentation to the sum on dsp_p (>= 2)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, cfg_len    job start pulse and length (sampled only in IDLE)
//   busy              high in RUN / DRAIN / DONE
//   in_valid/in_ready operand stream handshake, in_a / in_b operands
//   dsp_a, dsp_b      operands to the slice (0 on bubble cycles)
//   dsp_opmode        OPMODE to the slice
//   dsp_ce, dsp_rst   slice clock enable / reset
//   dsp_p             slice P output
//   res_valid         one-cycle result strobe, res_data held result
//   stall_cnt         (only with DSP_MAC_STALL_CNT_EN) count of RUN cycles
//                     without a valid operand, saturating at 16'hFFFF
//
// Optional feature macro: DSP_MAC_STALL_CNT_EN
// -----------------------------------------------------------------------------
module dsp_mac_sequencer #(
    parameter int LEN_W  = 10,
    parameter int OP_DLY = 1,
    parameter int P_LAT  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p,
    output logic             res_valid,
    output logic [47:0]      res_data
`ifdef DSP_MAC_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // active: slot belongs to a job (RUN/DRAIN); valid: carries an operand
    // pair; first: first pair of the job (clears the accumulator).
    typedef struct packed {
        logic active;
        logic valid;
        logic first;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);
    localparam int DRN_W = (P_LAT > 2) ? $clog2(P_LAT) : 1;

    localparam logic [7:0] OPM_IDLE  = 8'b0000_0000;
    localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
    localparam logic [7:0] OPM_ACC   = 8'b0000_1001;
    localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic               first_q, first_d;
    logic               zero_job_q, zero_job_d;
    logic               res_valid_q;
    logic [47:0]        res_data_q;
    logic               xfer;
    tag_t               push_tag;
    tag_t               opm_tag;

    // Slot tags travel through a chain of OP_DLY registers.
    logic [TAG_W*(OP_DLY+1)-1:0] tag_chain;

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        drain_d    = drain_q;
        first_d    = first_q;
        zero_job_d = zero_job_q;
        xfer       = 1'b0;
        push_tag   = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = cfg_len;
                    first_d = 1'b1;
                    if (cfg_len == '0) begin
                        zero_job_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        zero_job_d = 1'b0;
                        state_d    = S_RUN;
                    end
                end
            end
            S_RUN: begin
                push_tag.active = 1'b1;
                if (in_valid) begin
                    xfer           = 1'b1;
                    push_tag.valid = 1'b1;
                    push_tag.first = first_q;
                    first_d        = 1'b0;
                    rem_d          = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                        // Last slot appears on P P_LAT cycles after its
                        // presentation; DRAIN covers P_LAT-1 of those.
                        drain_d = DRN_W'(P_LAT - 2);
                    end
                end
            end
            S_DRAIN: begin
                push_tag.active = 1'b1;
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            drain_q     <= '0;
            first_q     <= 1'b0;
            zero_job_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            drain_q     <= drain_d;
            first_q     <= first_d;
            zero_job_q  <= zero_job_d;
            res_valid_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                // An empty job never touched the slice, so P is meaningless.
                res_data_q <= zero_job_q ? 48'd0 : dsp_p;
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot tag pipeline
    // ------------------------------------------------------------------
    assign tag_chain[TAG_W-1:0] = push_tag;

    genvar gi;
    generate
        for (gi = 0; gi < OP_DLY; gi++) begin : g_slot
            tag_t stage_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= tag_t'(tag_chain[TAG_W*gi +: TAG_W]);
                end
            end
            assign tag_chain[TAG_W*(gi+1) +: TAG_W] = stage_q;
        end
    endgenerate

    assign opm_tag = tag_t'(tag_chain[TAG_W*OP_DLY +: TAG_W]);

    always_comb begin
        dsp_opmode = OPM_IDLE;
        if (opm_tag.active) begin
            if (!opm_tag.valid) begin
                dsp_opmode = OPM_HOLD;
            end else if (opm_tag.first) begin
                dsp_opmode = OPM_FIRST;
            end else begin
                dsp_opmode = OPM_ACC;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_RUN);
    assign dsp_a     = xfer ? in_a : 18'd0;
    assign dsp_b     = xfer ? in_b : 18'd0;
    assign dsp_ce    = ~rst;
    assign dsp_rst   = rst;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

`ifdef DSP_MAC_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            stall_q <= '0;
        end else if (state_q == S_RUN && !in_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
